geo_ram_port: RTL and testbench

GEO_RAM_PORT -- requirements
Module: geo_ram_port

---
 rtl/geo_ram_pkg.sv | 27 ++
 rtl/geo_ram_port_if.sv | 25 ++
 rtl/geo_tag_fifo.sv | 48 ++++
 rtl/geo_ram_port.sv | 154 +++++++++++++++
 tb/tb_geo_ram_port.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/geo_ram_pkg.sv
// Shared types and default sizes for the geometry RAM port.
package geo_ram_pkg;

   localparam int ADDR_W          = 32;
   localparam int DATA_W          = 16;
   localparam int CMD_DEPTH_DEF   = 16;
   localparam int TAG_DEPTH_DEF   = 16;
   localparam int BUSY_MARGIN_DEF = 4;

   // Request kind: COPY-channel read, read/modify/write read, write.
   typedef enum logic [1:0] {
      KIND_RD_C = 2'd0,
      KIND_RD   = 2'd1,
      KIND_WR   = 2'd2
   } kind_t;

   typedef struct packed {
      kind_t             kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   function automatic logic is_read(kind_t k);
      return k != KIND_WR;
   endfunction

endpackage

// File: rtl/geo_ram_port_if.sv
// Memory-side command/return bus of the geometry RAM port.
interface geo_ram_port_if;
   import geo_ram_pkg::*;

   logic              mem_cmd_valid;
   logic              mem_cmd_ready;
   logic              mem_cmd_write;
   logic [ADDR_W-1:0] mem_cmd_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_rd_valid;
   logic [DATA_W-1:0] mem_rd_data;

   // The port issues commands and consumes read returns.
   modport master (
      output mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wr_data,
      input  mem_cmd_ready, mem_rd_valid, mem_rd_data
   );

   // The memory accepts commands and produces read returns.
   modport slave (
      input  mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_wr_data,
      output mem_cmd_ready, mem_rd_valid, mem_rd_data
   );

endinterface

// File: rtl/geo_tag_fifo.sv
// Single-push/single-pop FIFO holding the channel of each outstanding read.
// A push and a pop may share a cycle even when full; when empty, a pop in
// the same cycle as a push takes the pushed value straight through.
module geo_tag_fifo
#(
   parameter int DEPTH = 16,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0]  store [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = ((wr_ptr - rd_ptr) == PW'(DEPTH));
   assign push_ok  = push && (!full || pop);
   assign pop_ok   = pop && (!empty || push);
   assign pop_data = empty ? push_data : store[rd_ptr[AW-1:0]];

   // Storage write; contents need no reset since the pointers gate them.
   always_ff @(posedge clk) begin
      if (push_ok) store[wr_ptr[AW-1:0]] <= push_data;
   end

   // Pointer update; extra MSB distinguishes full from empty and wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_ok);
         rd_ptr <= rd_ptr + PW'(pop_ok);
      end
   end

endmodule

// File: rtl/geo_ram_port.sv
// Geometry RAM port: merges COPY reads, RMW reads and writes into one
// in-order memory command stream and routes read returns to their channel.
module geo_ram_port
   import geo_ram_pkg::*;
#(
   parameter int CMD_DEPTH   = CMD_DEPTH_DEF,
   parameter int TAG_DEPTH   = TAG_DEPTH_DEF,
   parameter int BUSY_MARGIN = BUSY_MARGIN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic              rd_req_C,
   input  logic              wr_ena,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic [ADDR_W-1:0] ram_addr_C,
   input  logic [DATA_W-1:0] ram_wr_data,
   output logic              ram_mux_busy,
   output logic              rd_data_rdy,
   output logic              rd_data_rdy_C,
   output logic [DATA_W-1:0] rd_data_in,
   output logic [DATA_W-1:0] rd_data_in_C,
   output logic              err_orphan,
   geo_ram_port_if.master    mem
);

   localparam int            AW       = $clog2(CMD_DEPTH);
   localparam int            PW       = AW + 1;
   localparam logic [PW-1:0] DEPTH_P  = PW'(CMD_DEPTH);
   localparam logic [PW-1:0] MARGIN_P = PW'(BUSY_MARGIN);

   entry_t        fifo_mem [CMD_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, count, free, count_next;
   entry_t        new_ent  [3];
   logic [PW-1:0] slot_ptr [3];
   logic [2:0]    req_v, acc;
   logic [1:0]    n_push;
   logic          drop;
   entry_t        head;
   logic          empty, head_rd, cmd_valid, pop;
   logic          tag_push, tag_pop, tag_out, tag_full, tag_empty, tag_avail, orphan;

   assign count = wr_ptr - rd_ptr;
   assign free  = DEPTH_P - count;
   assign empty = (count == '0);

   // Slot 0 is served first, so this ordering fixes C, RMW, write priority.
   assign req_v = {wr_ena, rd_req, rd_req_C};

   // Build the three candidate entries; reads carry no data.
   always_comb begin
      new_ent[0] = '{kind: KIND_RD_C, addr: ram_addr_C, data: '0};
      new_ent[1] = '{kind: KIND_RD,   addr: ram_addr,   data: '0};
      new_ent[2] = '{kind: KIND_WR,   addr: ram_addr,   data: ram_wr_data};
   end

   // Allocate consecutive slots to the active requests while space remains.
   always_comb begin
      n_push = '0;
      drop   = 1'b0;
      acc    = '0;
      for (int i = 0; i < 3; i++) begin
         slot_ptr[i] = wr_ptr + PW'(n_push);
         if (req_v[i]) begin
            if (PW'(n_push) < free) begin
               acc[i] = 1'b1;
               n_push = n_push + 2'd1;
            end else begin
               drop = 1'b1;
            end
         end
      end
   end

   // Request storage write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (acc[i]) fifo_mem[slot_ptr[i][AW-1:0]] <= new_ent[i];
   end

   // Head presentation; a read head waits for a tag slot, which a return in
   // the same cycle frees.
   assign head      = fifo_mem[rd_ptr[AW-1:0]];
   assign head_rd   = is_read(head.kind);
   assign cmd_valid = !empty && (!head_rd || !tag_full || mem.mem_rd_valid);
   assign pop       = cmd_valid && mem.mem_cmd_ready;

   assign mem.mem_cmd_valid = cmd_valid;
   assign mem.mem_cmd_write = !empty && (head.kind == KIND_WR);
   assign mem.mem_cmd_addr  = empty ? '0 : head.addr;
   assign mem.mem_wr_data   = empty ? '0 : head.data;

   assign count_next = count + PW'(n_push) - PW'(pop);

   // Request pointers and registered back-pressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         ram_mux_busy <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr + PW'(n_push);
         rd_ptr       <= rd_ptr + PW'(pop);
         ram_mux_busy <= (DEPTH_P - count_next) < MARGIN_P;
      end
   end

   // Writers are expected to honour ram_mux_busy; overflow is a design bug.
   always_ff @(posedge clk) begin
      if (!reset) assert (!drop);
   end

   // Tag tracking: 1 marks a COPY-channel read.
   assign tag_push  = pop && head_rd;
   assign tag_avail = !tag_empty || tag_push;
   assign tag_pop   = mem.mem_rd_valid && tag_avail;
   assign orphan    = mem.mem_rd_valid && !tag_avail;

   geo_tag_fifo #(.DEPTH(TAG_DEPTH), .W(1)) u_tag (
      .clk       (clk),
      .reset     (reset),
      .push      (tag_push),
      .push_data (head.kind == KIND_RD_C),
      .pop       (tag_pop),
      .pop_data  (tag_out),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   // Route each return to its channel one cycle later; flag orphan data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_rdy   <= 1'b0;
         rd_data_rdy_C <= 1'b0;
         rd_data_in    <= '0;
         rd_data_in_C  <= '0;
         err_orphan    <= 1'b0;
      end else begin
         rd_data_rdy   <= 1'b0;
         rd_data_rdy_C <= 1'b0;
         if (tag_pop) begin
            if (tag_out) begin
               rd_data_rdy_C <= 1'b1;
               rd_data_in_C  <= mem.mem_rd_data;
            end else begin
               rd_data_rdy   <= 1'b1;
               rd_data_in    <= mem.mem_rd_data;
            end
         end
         if (orphan) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_geo_ram_port.sv
// Bench for geo_ram_port: queue-based model of request order, outstanding
// reads and return routing, driven by directed scenarios and random traffic.
module tb_geo_ram_port;
   import geo_ram_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd_req = 1'b0, rd_req_C = 1'b0, wr_ena = 1'b0;
   logic [31:0] ram_addr = '0, ram_addr_C = '0;
   logic [15:0] ram_wr_data = '0;
   logic        ram_mux_busy, rd_data_rdy, rd_data_rdy_C, err_orphan;
   logic [15:0] rd_data_in, rd_data_in_C;

   always #5 clk = ~clk;

   geo_ram_port_if mem_bus ();

   geo_ram_port dut (
      .clk           (clk),
      .reset         (reset),
      .rd_req        (rd_req),
      .rd_req_C      (rd_req_C),
      .wr_ena        (wr_ena),
      .ram_addr      (ram_addr),
      .ram_addr_C    (ram_addr_C),
      .ram_wr_data   (ram_wr_data),
      .ram_mux_busy  (ram_mux_busy),
      .rd_data_rdy   (rd_data_rdy),
      .rd_data_rdy_C (rd_data_rdy_C),
      .rd_data_in    (rd_data_in),
      .rd_data_in_C  (rd_data_in_C),
      .err_orphan    (err_orphan),
      .mem           (mem_bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   entry_t      cmdq [$];   // requests accepted, not yet issued
   bit          tagq [$];   // issued reads awaiting return (1 = COPY)
   logic        exp_rdy = 1'b0, exp_rdy_c = 1'b0, m_err = 1'b0;
   logic [15:0] m_data = '0, m_data_c = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      cmdq.delete();
      tagq.delete();
      exp_rdy = 1'b0; exp_rdy_c = 1'b0; m_err = 1'b0;
      m_data = '0; m_data_c = '0;
   endtask

   // One clock: check outputs against the model, advance the model, clock.
   task automatic cycle();
      entry_t e;
      bit     ev, fire, ch;
      #1;
      check("rdy",    rd_data_rdy,   exp_rdy);
      check("rdy_c",  rd_data_rdy_C, exp_rdy_c);
      check("data",   rd_data_in,    m_data);
      check("data_c", rd_data_in_C,  m_data_c);
      check("err",    err_orphan,    m_err);
      check("busy",   ram_mux_busy,  (16 - cmdq.size()) < 4);
      ev = cmdq.size() > 0 &&
           (cmdq[0].kind == KIND_WR || tagq.size() < 16 ||
            (mem_bus.mem_rd_valid && tagq.size() > 0));
      check("cmd_valid", mem_bus.mem_cmd_valid, ev);
      if (ev) begin
         check("cmd_write", mem_bus.mem_cmd_write, cmdq[0].kind == KIND_WR);
         check("cmd_addr",  mem_bus.mem_cmd_addr,  cmdq[0].addr);
         if (cmdq[0].kind == KIND_WR) check("wr_data", mem_bus.mem_wr_data, cmdq[0].data);
      end
      fire = ev && mem_bus.mem_cmd_ready;
      exp_rdy = 1'b0; exp_rdy_c = 1'b0;
      if (mem_bus.mem_rd_valid) begin
         if (tagq.size() > 0) begin
            ch = tagq.pop_front();
            if (ch) begin exp_rdy_c = 1'b1; m_data_c = mem_bus.mem_rd_data; end
            else    begin exp_rdy   = 1'b1; m_data   = mem_bus.mem_rd_data; end
         end else begin
            m_err = 1'b1;
         end
      end
      if (fire) begin
         e = cmdq.pop_front();
         if (e.kind != KIND_WR) tagq.push_back(e.kind == KIND_RD_C);
      end
      if (rd_req_C) cmdq.push_back('{kind: KIND_RD_C, addr: ram_addr_C, data: 16'h0});
      if (rd_req)   cmdq.push_back('{kind: KIND_RD,   addr: ram_addr,   data: 16'h0});
      if (wr_ena)   cmdq.push_back('{kind: KIND_WR,   addr: ram_addr,   data: ram_wr_data});
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0; rd_req_C = 1'b0; wr_ena = 1'b0;
      mem_bus.mem_rd_valid = 1'b0;
   endtask

   // Issue everything queued and return every outstanding read.
   task automatic drain();
      int k;
      mem_bus.mem_cmd_ready = 1'b1;
      for (k = 0; k < 300; k++) begin
         if (cmdq.size() == 0 && tagq.size() == 0) break;
         if (tagq.size() > 0) begin
            mem_bus.mem_rd_valid = 1'b1;
            mem_bus.mem_rd_data  = 16'($urandom);
         end
         cycle();
      end
      check("drain_bound", 32'(k < 300), 32'd1);
      cycle();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, mem_bus.mem_cmd_valid, 0);
      check({tag, "_busy"},  ram_mux_busy,  0);
      check({tag, "_addr"},  mem_bus.mem_cmd_addr, 0);
      check({tag, "_wdata"}, mem_bus.mem_wr_data,  0);
      check({tag, "_rdy"},   rd_data_rdy,   0);
      check({tag, "_rdy_c"}, rd_data_rdy_C, 0);
      check({tag, "_err"},   err_orphan,    0);
      check({tag, "_data"},  rd_data_in,    0);
      check({tag, "_datac"}, rd_data_in_C,  0);
   endtask

   initial begin
      mem_bus.mem_cmd_ready = 1'b0;
      mem_bus.mem_rd_valid  = 1'b0;
      mem_bus.mem_rd_data   = '0;

      // Reset state.
      @(negedge clk);
      #1 check_zero("reset");
      cycle();
      reset = 1'b0;
      cycle();

      // Three requests in one cycle: order C read, RMW read, write.
      mem_bus.mem_cmd_ready = 1'b1;
      rd_req_C = 1'b1; ram_addr_C = 32'h100;
      rd_req   = 1'b1; ram_addr   = 32'h200;
      wr_ena   = 1'b1; ram_wr_data = 16'h1234;
      cycle();
      repeat (3) cycle();
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'h1111; cycle();
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'h2222; cycle();
      cycle();

      // Alternating channel returns.
      rd_req_C = 1'b1; ram_addr_C = 32'h300; cycle();
      rd_req   = 1'b1; ram_addr   = 32'h400; cycle();
      cycle();
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'hAAAA; cycle();
      check("aaaa_rdy_c", rd_data_rdy_C, 1);
      check("aaaa_data",  rd_data_in_C,  16'hAAAA);
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'h5555; cycle();
      check("5555_rdy",  rd_data_rdy, 1);
      check("5555_data", rd_data_in,  16'h5555);
      cycle();

      // Stalled memory, 13 single requests -> busy with 3 free, no drops.
      mem_bus.mem_cmd_ready = 1'b0;
      for (int i = 0; i < 13; i++) begin
         case (i % 3)
            0: begin rd_req_C = 1'b1; ram_addr_C = 32'h1000 + 32'(i); end
            1: begin rd_req   = 1'b1; ram_addr   = 32'h2000 + 32'(i); end
            default: begin wr_ena = 1'b1; ram_addr = 32'h3000 + 32'(i); ram_wr_data = 16'(i * 7); end
         endcase
         cycle();
      end
      check("busy13", ram_mux_busy, 1);
      cycle();
      drain();

      // 16 reads outstanding; the 17th waits for the first return.
      mem_bus.mem_cmd_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i[0]) begin rd_req_C = 1'b1; ram_addr_C = 32'h5000 + 32'(i); end
         else      begin rd_req   = 1'b1; ram_addr   = 32'h6000 + 32'(i); end
         cycle();
      end
      rd_req = 1'b1; ram_addr = 32'h7777; cycle();
      repeat (3) cycle();
      check("tag_full_stall", mem_bus.mem_cmd_valid, 0);
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'hBEEF; cycle();
      drain();

      // Orphan return.
      mem_bus.mem_rd_valid = 1'b1; mem_bus.mem_rd_data = 16'hDEAD; cycle();
      repeat (3) cycle();
      check("orphan_sticky", err_orphan, 1);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         mem_bus.mem_cmd_ready = ($urandom_range(0, 3) != 0);
         if (16 - cmdq.size() >= 4) begin
            rd_req_C    = 1'($urandom_range(0, 1));
            rd_req      = 1'($urandom_range(0, 1));
            wr_ena      = 1'($urandom_range(0, 1));
            ram_addr    = $urandom;
            ram_addr_C  = $urandom;
            ram_wr_data = 16'($urandom);
         end
         if (tagq.size() > 0 && $urandom_range(0, 1) == 1) begin
            mem_bus.mem_rd_valid = 1'b1;
            mem_bus.mem_rd_data  = 16'($urandom);
         end
         cycle();
      end
      drain();

      // Mid-operation reset with 5 queued entries.
      mem_bus.mem_cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr_ena = 1'b1; ram_addr = 32'h9000 + 32'(i); ram_wr_data = 16'hC0DE; cycle();
      end
      reset = 1'b1;
      #1 check_zero("async_rst");
      model_clear();
      @(negedge clk);
      cycle();
      reset = 1'b0;
      mem_bus.mem_cmd_ready = 1'b1;
      cycle();
      check("post_rst_empty", mem_bus.mem_cmd_valid, 0);
      rd_req = 1'b1; ram_addr = 32'hABC0; cycle();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
